// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: code width,
// glyph patterns (active-low {g,f,e,d,c,b,a}) and small sizing helpers.
// Latency: n/a (package). Backpressure: n/a.
package seven_seg_pkg;

  localparam int CODE_W     = 5;
  localparam int SUB_PHASES = 16;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [6:0]        seg_t;

  // Special (non-hex) codes.
  localparam code_t CODE_DASH  = 5'h10;
  localparam code_t CODE_H     = 5'h11;
  localparam code_t CODE_L     = 5'h12;
  localparam code_t CODE_P     = 5'h13;
  localparam code_t CODE_U     = 5'h14;
  localparam code_t CODE_BLANK = 5'h1F;

  // All segments dark.
  localparam seg_t SEG_OFF = 7'h7F;

  // Hex glyphs.
  localparam seg_t GLYPH_0 = 7'h40;
  localparam seg_t GLYPH_1 = 7'h79;
  localparam seg_t GLYPH_2 = 7'h24;
  localparam seg_t GLYPH_3 = 7'h30;
  localparam seg_t GLYPH_4 = 7'h19;
  localparam seg_t GLYPH_5 = 7'h12;
  localparam seg_t GLYPH_6 = 7'h02;
  localparam seg_t GLYPH_7 = 7'h78;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h10;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h03;
  localparam seg_t GLYPH_C = 7'h46;
  localparam seg_t GLYPH_D = 7'h21;
  localparam seg_t GLYPH_E = 7'h06;
  localparam seg_t GLYPH_F = 7'h0E;

  // Letter / symbol glyphs.
  localparam seg_t GLYPH_DASH = 7'h3F;
  localparam seg_t GLYPH_H    = 7'h09;
  localparam seg_t GLYPH_L    = 7'h47;
  localparam seg_t GLYPH_P    = 7'h0C;
  localparam seg_t GLYPH_U    = 7'h41;

  // Blink phase: HIDE darkens digits whose blink enable is set.
  typedef enum logic {
    BLINK_SHOW = 1'b0,
    BLINK_HIDE = 1'b1
  } blink_phase_e;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 5-bit display code to active-low seven-segment pattern.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: code (in, CODE_W) -> pattern (out, 7, {g,f,e,d,c,b,a} active-low).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      5'h00:     pattern = GLYPH_0;
      5'h01:     pattern = GLYPH_1;
      5'h02:     pattern = GLYPH_2;
      5'h03:     pattern = GLYPH_3;
      5'h04:     pattern = GLYPH_4;
      5'h05:     pattern = GLYPH_5;
      5'h06:     pattern = GLYPH_6;
      5'h07:     pattern = GLYPH_7;
      5'h08:     pattern = GLYPH_8;
      5'h09:     pattern = GLYPH_9;
      5'h0A:     pattern = GLYPH_A;
      5'h0B:     pattern = GLYPH_B;
      5'h0C:     pattern = GLYPH_C;
      5'h0D:     pattern = GLYPH_D;
      5'h0E:     pattern = GLYPH_E;
      5'h0F:     pattern = GLYPH_F;
      CODE_DASH: pattern = GLYPH_DASH;
      CODE_H:    pattern = GLYPH_H;
      CODE_L:    pattern = GLYPH_L;
      CODE_P:    pattern = GLYPH_P;
      CODE_U:    pattern = GLYPH_U;
      // 0x15..0x1F render dark.
      default:   pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed N-digit seven-segment driver with brightness PWM, blink and tear-free frame updates.
// Latency: outputs registered, 1 cycle after counter state; loaded data shows from the next frame start.
// Backpressure: none; the scan free-runs and load is an unhandshaked strobe (last load before a frame wins).
// Ports: clk, reset (async, active-high); signal_in[5*N] codes, dp_in[N], blink_en[N], load strobe;
//        brightness[4] live duty level; segments[7]/dp active-low; digits[N] active-low anodes; frame_done pulse.
module seven_seg_scan_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CODE_W*NUM_DIGITS-1:0] signal_in,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic [NUM_DIGITS-1:0]        blink_en,
  input  logic [3:0]                   brightness,
  input  logic                         load,
  output logic [6:0]                   segments,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        digits,
  output logic                         frame_done
);

  localparam int SUB_DIV = REFRESH_DIV / SUB_PHASES;
  localparam int PRESC_W = cnt_width(REFRESH_DIV);
  localparam int SUB_W   = cnt_width(SUB_DIV);
  localparam int IDX_W   = cnt_width(NUM_DIGITS);
  localparam int BLINK_W = cnt_width(BLINK_FRAMES);

  // ---------------------------------------------------------------------
  // Scan timing: prescaler, sub-phase tracker, digit index, blink state
  // ---------------------------------------------------------------------
  logic [PRESC_W-1:0] presc;
  logic [SUB_W-1:0]   sub_cnt;
  logic [3:0]         sub_phase;
  logic [IDX_W-1:0]   scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  blink_phase_e       blink_phase;

  logic slot_tick;
  logic last_digit;
  logic frame_wrap;

  assign slot_tick  = (presc == PRESC_W'(REFRESH_DIV - 1));
  assign last_digit = (scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = slot_tick && last_digit;

  // sub_phase tracks presc / SUB_DIV incrementally, avoiding a divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      scan_idx  <= '0;
    end else if (slot_tick) begin
      presc     <= '0;
      sub_cnt   <= '0;
      sub_phase <= '0;
      scan_idx  <= last_digit ? '0 : scan_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
      if (sub_cnt == SUB_W'(SUB_DIV - 1)) begin
        sub_cnt   <= '0;
        sub_phase <= sub_phase + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= BLINK_SHOW;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= (blink_phase == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Display data: staging captures every load, active switches only at a
  // frame wrap so a frame is always drawn from one consistent data set.
  // ---------------------------------------------------------------------
  logic [CODE_W*NUM_DIGITS-1:0] stage_code;
  logic [NUM_DIGITS-1:0]        stage_dp;
  logic [NUM_DIGITS-1:0]        stage_blink;
  logic [CODE_W*NUM_DIGITS-1:0] act_code;
  logic [NUM_DIGITS-1:0]        act_dp;
  logic [NUM_DIGITS-1:0]        act_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_code  <= {NUM_DIGITS{CODE_BLANK}};
      stage_dp    <= '0;
      stage_blink <= '0;
      act_code    <= {NUM_DIGITS{CODE_BLANK}};
      act_dp      <= '0;
      act_blink   <= '0;
    end else begin
      if (load) begin
        stage_code  <= signal_in;
        stage_dp    <= dp_in;
        stage_blink <= blink_en;
      end
      // A load coinciding with the wrap bypasses staging so it is not lost
      // for a whole frame.
      if (frame_wrap) begin
        act_code  <= load ? signal_in : stage_code;
        act_dp    <= load ? dp_in     : stage_dp;
        act_blink <= load ? blink_en  : stage_blink;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Selected digit and anode gating
  // ---------------------------------------------------------------------
  logic [CODE_W-1:0] sel_code;
  logic [6:0]        sel_glyph;
  logic              sel_dp;
  logic              sel_blink;
  logic              bright_ok;
  logic              has_content;
  logic              anode_on;

  assign sel_code  = act_code[CODE_W*int'(scan_idx) +: CODE_W];
  assign sel_dp    = act_dp[scan_idx];
  assign sel_blink = act_blink[scan_idx];

  seven_seg_decode u_decode (
    .code    (sel_code),
    .pattern (sel_glyph)
  );

  // With one cycle per sub-phase the ghost-blank cycle swallows all of
  // sub-phase 0; keeping slot cycle 1 lit preserves a visible minimum level.
  assign bright_ok   = (sub_phase <= brightness) || (presc == PRESC_W'(1));
  // A blank code with no decimal point has nothing to show; keep it dark.
  assign has_content = (sel_glyph != SEG_OFF) || sel_dp;
  // presc == 0 is the ghost-blanking cycle between adjacent digits.
  assign anode_on    = (presc != '0) && bright_ok && has_content
                     && !((blink_phase == BLINK_HIDE) && sel_blink);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments   <= SEG_OFF;
      dp         <= 1'b1;
      digits     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (anode_on) begin
        segments <= sel_glyph;
        dp       <= ~sel_dp;
        digits   <= ~(NUM_DIGITS'(1) << scan_idx);
      end else begin
        segments <= SEG_OFF;
        dp       <= 1'b1;
        digits   <= '1;
      end
    end
  end

endmodule
